// File: rtl/mem_access_responder.sv
// mem_access_responder
//   On-chip line memory that acts as the target of the cache memory access
//   protocol (MemAccessReq / MemAccessReqAck / MemAccessResult /
//   MemAccessResponse). Each cycle it can accept one line request. Reads
//   return {serial, data} and writes return {serial} in order, after
//   READ_LATENCY and WRITE_LATENCY cycles respectively.
//
// Ports
//   clk               : clock
//   rst               : synchronous active-high reset
//   memAccessReq      : {valid, we, addr, data} request from the port mux
//   memReqAck         : {ack, serial, wserial}, combinational in the request cycle
//   memAccessResult   : {valid, serial, data} read return
//   memAccessResponse : {valid, serial} write completion

package mem_access_responder_pkg;

    localparam int PHY_ADDR_WIDTH                 = 32;
    localparam int DCACHE_LINE_BYTE_NUM           = 8;
    localparam int DCACHE_LINE_BYTE_NUM_BIT_WIDTH = 3;
    localparam int DCACHE_LINE_WIDTH              = DCACHE_LINE_BYTE_NUM * 8;
    localparam int MEM_ACCESS_SERIAL_BIT_SIZE     = 2;
    localparam int MEM_WRITE_SERIAL_BIT_SIZE      = 1;

    typedef logic [PHY_ADDR_WIDTH-1:0]             PhyAddrPath;
    typedef logic [DCACHE_LINE_WIDTH-1:0]          DCacheLinePath;
    typedef logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] MemAccessSerial;
    typedef logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0]  MemWriteSerial;

    typedef struct packed {
        logic          valid;
        logic          we;
        PhyAddrPath    addr;
        DCacheLinePath data;
    } MemAccessReq;

    typedef struct packed {
        logic           ack;
        MemAccessSerial serial;
        MemWriteSerial  wserial;
    } MemAccessReqAck;

    typedef struct packed {
        logic           valid;
        MemAccessSerial serial;
        DCacheLinePath  data;
    } MemAccessResult;

    typedef struct packed {
        logic          valid;
        MemWriteSerial serial;
    } MemAccessResponse;

endpackage


module mem_access_responder
    import mem_access_responder_pkg::*;
#(
    parameter int unsigned MEM_LINE_NUM  = 1024,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned RD_Q_DEPTH    = 4,
    parameter int unsigned WR_Q_DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  MemAccessReq      memAccessReq,
    output MemAccessReqAck   memReqAck,
    output MemAccessResult   memAccessResult,
    output MemAccessResponse memAccessResponse
);

    localparam int unsigned LINE_IDX_W = $clog2(MEM_LINE_NUM);

    localparam int unsigned RD_PTR_W = (RD_Q_DEPTH > 1) ? $clog2(RD_Q_DEPTH) : 1;
    localparam int unsigned RD_CNT_W = $clog2(RD_Q_DEPTH + 1);
    localparam int unsigned RD_TMR_W = $clog2(READ_LATENCY + 1);
    localparam int unsigned WR_PTR_W = (WR_Q_DEPTH > 1) ? $clog2(WR_Q_DEPTH) : 1;
    localparam int unsigned WR_CNT_W = $clog2(WR_Q_DEPTH + 1);
    localparam int unsigned WR_TMR_W = $clog2(WRITE_LATENCY + 1);

    localparam logic [RD_PTR_W-1:0] RD_LAST     = RD_PTR_W'(RD_Q_DEPTH - 1);
    localparam logic [RD_CNT_W-1:0] RD_DEPTH_C  = RD_CNT_W'(RD_Q_DEPTH);
    localparam logic [RD_TMR_W-1:0] RD_TMR_INIT = RD_TMR_W'(READ_LATENCY - 1);
    localparam logic [WR_PTR_W-1:0] WR_LAST     = WR_PTR_W'(WR_Q_DEPTH - 1);
    localparam logic [WR_CNT_W-1:0] WR_DEPTH_C  = WR_CNT_W'(WR_Q_DEPTH);
    localparam logic [WR_TMR_W-1:0] WR_TMR_INIT = WR_TMR_W'(WRITE_LATENCY - 1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [LINE_IDX_W-1:0] req_line;
    logic                  unused_req_addr;

    // Byte offset and bits above the line index are deliberately dropped:
    // addresses alias modulo MEM_LINE_NUM lines.
    assign req_line        = memAccessReq.addr[DCACHE_LINE_BYTE_NUM_BIT_WIDTH +: LINE_IDX_W];
    assign unused_req_addr = ^memAccessReq.addr;

    // ------------------------------------------------------------------
    // Line RAM (not reset)
    // ------------------------------------------------------------------
    DCacheLinePath ram_q [MEM_LINE_NUM];
    DCacheLinePath ram_rdata_q;

    // ------------------------------------------------------------------
    // Read queue state
    // ------------------------------------------------------------------
    MemAccessSerial      rd_serial_q [RD_Q_DEPTH];
    DCacheLinePath       rd_data_q   [RD_Q_DEPTH];
    logic [RD_TMR_W-1:0] rd_tmr_q    [RD_Q_DEPTH];

    logic [RD_PTR_W-1:0] rd_head_q,  rd_head_d;
    logic [RD_PTR_W-1:0] rd_tail_q,  rd_tail_d;
    logic [RD_CNT_W-1:0] rd_count_q, rd_count_d;
    MemAccessSerial      rd_ser_q,   rd_ser_d;
    logic                rd_fill_q,  rd_fill_d;
    logic [RD_PTR_W-1:0] rd_fill_idx_q, rd_fill_idx_d;

    logic rd_pop;
    logic rd_ack;
    logic rd_push;

    // ------------------------------------------------------------------
    // Write queue state
    // ------------------------------------------------------------------
    MemWriteSerial       wr_serial_q [WR_Q_DEPTH];
    logic [WR_TMR_W-1:0] wr_tmr_q    [WR_Q_DEPTH];

    logic [WR_PTR_W-1:0] wr_head_q,  wr_head_d;
    logic [WR_PTR_W-1:0] wr_tail_q,  wr_tail_d;
    logic [WR_CNT_W-1:0] wr_count_q, wr_count_d;
    MemWriteSerial       wr_ser_q,   wr_ser_d;

    logic wr_pop;
    logic wr_ack;
    logic wr_push;

    function automatic logic [RD_PTR_W-1:0] rd_next(input logic [RD_PTR_W-1:0] p);
        return (p == RD_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [WR_PTR_W-1:0] wr_next(input logic [WR_PTR_W-1:0] p);
        return (p == WR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Accept / pop decisions
    // ------------------------------------------------------------------
    // The head leaves in the same cycle it is presented on the result port,
    // so a full queue whose head is leaving can still take a new entry.
    assign rd_pop  = (rd_count_q != '0) && (rd_tmr_q[rd_head_q] == '0);
    assign wr_pop  = (wr_count_q != '0) && (wr_tmr_q[wr_head_q] == '0);

    assign rd_ack  = memAccessReq.valid && !memAccessReq.we &&
                     ((rd_count_q < RD_DEPTH_C) || rd_pop);
    assign wr_ack  = memAccessReq.valid &&  memAccessReq.we &&
                     ((wr_count_q < WR_DEPTH_C) || wr_pop);

    // A reset in the acceptance cycle squashes the request entirely.
    assign rd_push = rd_ack && !rst;
    assign wr_push = wr_ack && !rst;

    always_comb begin
        memReqAck         = '0;
        memReqAck.ack     = rd_ack || wr_ack;
        memReqAck.serial  = rd_ser_q;
        memReqAck.wserial = wr_ser_q;
    end

    // ------------------------------------------------------------------
    // Next-state for pointers, counts and serials
    // ------------------------------------------------------------------
    always_comb begin
        rd_head_d     = rd_pop  ? rd_next(rd_head_q) : rd_head_q;
        rd_tail_d     = rd_push ? rd_next(rd_tail_q) : rd_tail_q;
        rd_ser_d      = rd_push ? rd_ser_q + 1'b1 : rd_ser_q;
        rd_fill_d     = rd_push;
        rd_fill_idx_d = rd_tail_q;
        rd_count_d    = rd_count_q;
        if (rd_push && !rd_pop) begin
            rd_count_d = rd_count_q + 1'b1;
        end else if (!rd_push && rd_pop) begin
            rd_count_d = rd_count_q - 1'b1;
        end
    end

    always_comb begin
        wr_head_d  = wr_pop  ? wr_next(wr_head_q) : wr_head_q;
        wr_tail_d  = wr_push ? wr_next(wr_tail_q) : wr_tail_q;
        wr_ser_d   = wr_push ? wr_ser_q + 1'b1 : wr_ser_q;
        wr_count_d = wr_count_q;
        if (wr_push && !wr_pop) begin
            wr_count_d = wr_count_q + 1'b1;
        end else if (!wr_push && wr_pop) begin
            wr_count_d = wr_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_head_q     <= '0;
            rd_tail_q     <= '0;
            rd_count_q    <= '0;
            rd_ser_q      <= '0;
            rd_fill_q     <= 1'b0;
            rd_fill_idx_q <= '0;
            wr_head_q     <= '0;
            wr_tail_q     <= '0;
            wr_count_q    <= '0;
            wr_ser_q      <= '0;
        end else begin
            rd_head_q     <= rd_head_d;
            rd_tail_q     <= rd_tail_d;
            rd_count_q    <= rd_count_d;
            rd_ser_q      <= rd_ser_d;
            rd_fill_q     <= rd_fill_d;
            rd_fill_idx_q <= rd_fill_idx_d;
            wr_head_q     <= wr_head_d;
            wr_tail_q     <= wr_tail_d;
            wr_count_q    <= wr_count_d;
            wr_ser_q      <= wr_ser_d;
        end
    end

    // ------------------------------------------------------------------
    // Queue payload storage. Slots outside [head, head+count) are dead, so
    // these arrays need no reset: a reset clears count and orphans them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RD_Q_DEPTH; i++) begin
            if (rd_tmr_q[RD_PTR_W'(i)] != '0) begin
                rd_tmr_q[RD_PTR_W'(i)] <= rd_tmr_q[RD_PTR_W'(i)] - 1'b1;
            end
        end
        if (rd_push) begin
            rd_tmr_q[rd_tail_q]    <= RD_TMR_INIT;
            rd_serial_q[rd_tail_q] <= rd_ser_q;
        end
        // Line data arrives from the synchronous RAM read one cycle after
        // acceptance and is parked in the slot that was pushed then.
        if (rd_fill_q) begin
            rd_data_q[rd_fill_idx_q] <= ram_rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WR_Q_DEPTH; i++) begin
            if (wr_tmr_q[WR_PTR_W'(i)] != '0) begin
                wr_tmr_q[WR_PTR_W'(i)] <= wr_tmr_q[WR_PTR_W'(i)] - 1'b1;
            end
        end
        if (wr_push) begin
            wr_tmr_q[wr_tail_q]    <= WR_TMR_INIT;
            wr_serial_q[wr_tail_q] <= wr_ser_q;
        end
    end

    // A read and a write are never accepted together, so the registered
    // read here equals the array contents at the start of the next cycle.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            ram_q[req_line] <= memAccessReq.data;
        end
        if (rd_push) begin
            ram_rdata_q <= ram_q[req_line];
        end
    end

    // ------------------------------------------------------------------
    // Return ports: driven from queue flops only, zero when idle.
    // With READ_LATENCY == 1 the head pops in its fill cycle, so its data
    // is taken straight from the RAM read register.
    // ------------------------------------------------------------------
    always_comb begin
        memAccessResult = '0;
        if (rd_pop) begin
            memAccessResult.valid  = 1'b1;
            memAccessResult.serial = rd_serial_q[rd_head_q];
            memAccessResult.data   = (READ_LATENCY == 1) ? ram_rdata_q : rd_data_q[rd_head_q];
        end
    end

    always_comb begin
        memAccessResponse = '0;
        if (wr_pop) begin
            memAccessResponse.valid  = 1'b1;
            memAccessResponse.serial = wr_serial_q[wr_head_q];
        end
    end

endmodule
